cache: RTL and testbench

//   Parameterised set-associative data cache storing 32-bit words, with no backing memory.

---
 rtl/cache_if.sv | 15 +
 rtl/cache.sv | 136 +++++++++++++
 tb/tb_cache.sv | 103 ++++++++++
 3 files changed

// File: rtl/cache_if.sv
// Load/store port between a core and the cache.
// The master drives requests; the slave returns one registered result per access.
interface cache_if;
   logic [31:0] address;
   logic [31:0] data_in;
   logic        valid_in;
   logic        write_enable;
   logic [31:0] data_out;
   logic        valid_out;

   modport master (output address, data_in, valid_in, write_enable,
                   input  data_out, valid_out);
   modport slave  (input  address, data_in, valid_in, write_enable,
                   output data_out, valid_out);
endinterface

// File: rtl/cache.sv
// Set-associative write-allocate word cache with round-robin replacement and 1-cycle registered result.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
module cache #(
   parameter int BLOCK_SIZE    = 32,
   parameter int ASSOCIATIVITY = 4,
   parameter int SET_SIZE      = 64
) (
   input  logic        clk,
   input  logic        rst_n,
`ifdef CACHE_STATS_EN
   output logic [31:0] hit_count,
   output logic [31:0] miss_count,
`endif
   cache_if.slave      bus
);
   localparam int WPL    = BLOCK_SIZE / 4;
   localparam int OFF    = $clog2(BLOCK_SIZE);
   localparam int IDX    = $clog2(SET_SIZE);
   localparam int TAG_W  = 32 - OFF - IDX;
   localparam int LINES  = SET_SIZE * ASSOCIATIVITY;
   localparam int WSW    = (WPL > 1) ? $clog2(WPL) : 1;
   localparam int IDXW   = (IDX > 0) ? IDX : 1;
   localparam int WAYB   = (ASSOCIATIVITY > 1) ? $clog2(ASSOCIATIVITY) : 1;
   localparam int LINE_W = (LINES > 1) ? $clog2(LINES) : 1;
   localparam int DATA_W = (LINES * WPL > 1) ? $clog2(LINES * WPL) : 1;

   logic [WSW-1:0]    word_sel;
   logic [IDXW-1:0]   set_idx;
   logic [TAG_W-1:0]  tag;

   logic [TAG_W-1:0]  tag_mem  [LINES];
   logic [31:0]       data_mem [LINES*WPL];
   logic [LINES-1:0]  line_valid_reg;
   logic [WPL-1:0]    wvalid_reg [LINES];
   logic [WAYB-1:0]   ptr_reg    [SET_SIZE];

   logic [LINE_W-1:0]        line_idx [ASSOCIATIVITY];
   logic [ASSOCIATIVITY-1:0] tag_hit;
   logic                     line_hit, read_hit, has_invalid;
   logic [WAYB-1:0]          hit_way, inv_way, wr_way;
   logic [LINE_W-1:0]        hit_line, wr_line;
   logic [31:0]              rd_word;

   wire unused_addr = &{1'b0, bus.address[1:0]};

   generate
      if (WPL > 1) begin : g_word
         assign word_sel = bus.address[OFF-1:2];
      end else begin : g_word1
         assign word_sel = '0;
      end
      if (IDX > 0) begin : g_idx
         assign set_idx = bus.address[OFF+IDX-1:OFF];
      end else begin : g_idx1
         assign set_idx = '0;
      end
      for (genvar gi = 0; gi < ASSOCIATIVITY; gi++) begin : g_way
         assign line_idx[gi] = LINE_W'(int'(set_idx) * ASSOCIATIVITY + gi);
         assign tag_hit[gi]  = line_valid_reg[line_idx[gi]] && (tag_mem[line_idx[gi]] == tag);
      end
   endgenerate

   assign tag = bus.address[31:OFF+IDX];

   // Lowest-numbered matching / invalid way wins; descending scan leaves the lowest last.
   always_comb begin
      hit_way     = '0;
      inv_way     = '0;
      has_invalid = 1'b0;
      for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
         if (tag_hit[w]) hit_way = WAYB'(w);
         if (!line_valid_reg[line_idx[w]]) begin
            has_invalid = 1'b1;
            inv_way     = WAYB'(w);
         end
      end
   end

   assign line_hit = |tag_hit;
   assign hit_line = line_idx[hit_way];
   assign read_hit = line_hit && wvalid_reg[hit_line][word_sel];
   assign rd_word  = data_mem[DATA_W'(int'(hit_line) * WPL + int'(word_sel))];
   assign wr_way   = line_hit ? hit_way : (has_invalid ? inv_way : ptr_reg[set_idx]);
   assign wr_line  = line_idx[wr_way];

   // Tag and data storage carry no reset; the valid bits alone decide what is live.
   always_ff @(posedge clk) begin
      if (rst_n && bus.valid_in && bus.write_enable) begin
         tag_mem[wr_line] <= tag;
         data_mem[DATA_W'(int'(wr_line) * WPL + int'(word_sel))] <= bus.data_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_valid_reg <= '0;
         for (int l = 0; l < LINES; l++) wvalid_reg[l] <= '0;
         for (int s = 0; s < SET_SIZE; s++) ptr_reg[s] <= '0;
         bus.data_out  <= '0;
         bus.valid_out <= 1'b0;
      end else if (bus.valid_in) begin
         if (bus.write_enable) begin
            line_valid_reg[wr_line] <= 1'b1;
            if (line_hit) begin
               wvalid_reg[wr_line][word_sel] <= 1'b1;
            end else begin
               wvalid_reg[wr_line] <= WPL'(1) << word_sel;
               if (!has_invalid && ASSOCIATIVITY > 1)
                  ptr_reg[set_idx] <= ptr_reg[set_idx] + 1'b1;
            end
            bus.data_out  <= bus.data_in;
            bus.valid_out <= 1'b1;
         end else begin
            bus.data_out  <= read_hit ? rd_word : 32'd0;
            bus.valid_out <= read_hit;
         end
      end else begin
         bus.valid_out <= 1'b0;
      end
   end

`ifdef CACHE_STATS_EN
   logic access_hit;
   assign access_hit = bus.write_enable ? line_hit : read_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (bus.valid_in) begin
         if (access_hit) hit_count  <= hit_count + 32'd1;
         else            miss_count <= miss_count + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_cache.sv
// Directed test of the cache: cold miss, write/read, partial line, round-robin eviction, idle, async reset.
module tb_cache;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   cache_if bus ();

   cache #(.BLOCK_SIZE(32), .ASSOCIATIVITY(4), .SET_SIZE(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef CACHE_STATS_EN
      .hit_count  (),
      .miss_count (),
`endif
      .bus   (bus.slave)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One access: drive on the falling edge, sample 1 ns after the rising edge.
   task automatic access(input string tag, input logic vld, input logic we,
                         input logic [31:0] addr, input logic [31:0] din,
                         input logic exp_v, input logic [31:0] exp_d);
      @(negedge clk);
      bus.valid_in     = vld;
      bus.write_enable = we;
      bus.address      = addr;
      bus.data_in      = din;
      @(posedge clk);
      #1;
      $display("%s v=%0b we=%0b addr=0x%08h din=0x%08h -> valid_out=%0b data_out=0x%08h",
               tag, vld, we, addr, din, bus.valid_out, bus.data_out);
      check_eq({tag, ".valid"}, {31'd0, bus.valid_out}, {31'd0, exp_v});
      check_eq({tag, ".data"}, bus.data_out, exp_d);
   endtask

   initial begin
      bus.valid_in     = 1'b0;
      bus.write_enable = 1'b0;
      bus.address      = '0;
      bus.data_in      = '0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset.valid", {31'd0, bus.valid_out}, 32'd0);
      check_eq("reset.data", bus.data_out, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      access("cold_rd",    1, 0, 32'd100,   32'd0,        0, 32'd0);
      access("wr_40",      1, 1, 32'h40,    32'hDEADBEEF, 1, 32'hDEADBEEF);
      access("rd_40",      1, 0, 32'h40,    32'd0,        1, 32'hDEADBEEF);
      access("rd_44_part", 1, 0, 32'h44,    32'd0,        0, 32'd0);
      access("wr_44",      1, 1, 32'h44,    32'd5,        1, 32'd5);
      access("rd_44",      1, 0, 32'h44,    32'd0,        1, 32'd5);
      access("rd_40_again",1, 0, 32'h40,    32'd0,        1, 32'hDEADBEEF);

      // Fill set 0 with four tags, then allocate a fifth (evicts way 0, pointer -> 1).
      access("wr_0000",    1, 1, 32'h0000,  32'h11, 1, 32'h11);
      access("wr_0800",    1, 1, 32'h0800,  32'h22, 1, 32'h22);
      access("wr_1000",    1, 1, 32'h1000,  32'h33, 1, 32'h33);
      access("wr_1800",    1, 1, 32'h1800,  32'h44, 1, 32'h44);
      access("wr_2000",    1, 1, 32'h2000,  32'h55, 1, 32'h55);
      access("rd_0000_ev", 1, 0, 32'h0000,  32'd0,  0, 32'd0);
      access("rd_0800",    1, 0, 32'h0800,  32'd0,  1, 32'h22);
      access("rd_2000",    1, 0, 32'h2000,  32'd0,  1, 32'h55);
      // Next allocation uses pointer way 1, evicting 0x0800.
      access("wr_2800",    1, 1, 32'h2800,  32'h66, 1, 32'h66);
      access("rd_0800_ev", 1, 0, 32'h0800,  32'd0,  0, 32'd0);
      access("rd_1000",    1, 0, 32'h1000,  32'd0,  1, 32'h33);
      access("rd_2800",    1, 0, 32'h2800,  32'd0,  1, 32'h66);

      // Idle cycle: no state change and data_out keeps the previous result.
      access("idle",       0, 1, 32'h40,    32'd7,  0, 32'h66);
      access("rd_40_idle", 1, 0, 32'h40,    32'd0,  1, 32'hDEADBEEF);
      access("wr_40_new",  1, 1, 32'h40,    32'h12345678, 1, 32'h12345678);
      access("rd_40_new",  1, 0, 32'h40,    32'd0,  1, 32'h12345678);

      // Asynchronous reset between edges clears the outputs at once.
      #2;
      rst_n = 1'b0;
      #1;
      $display("async_rst -> valid_out=%0b data_out=0x%08h", bus.valid_out, bus.data_out);
      check_eq("async_rst.valid", {31'd0, bus.valid_out}, 32'd0);
      check_eq("async_rst.data", bus.data_out, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      access("rd_40_post", 1, 0, 32'h40,    32'd0,  0, 32'd0);
      access("rd_1000_post",1, 0, 32'h1000, 32'd0,  0, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
